// File: rtl/hbridge_drive.sv
// hbridge_drive: decodes the synchronised {in1,in2} command and drives two H-bridge legs
//   with break-before-make dead time on reversal, brake mode and soft-start PWM.
// Latency: stable command -> state on 3rd rising edge, out_a/out_b on the 4th.
// Backpressure: none; commands are levels, busy flags the dead-time window.
// Ports: clk, rst_n (async active-low); in1/in2 async command bits;
//   out_a/out_b registered leg drives; state (0 STOP,1 FWD,2 REV,3 DEAD,4 BRAKE);
//   duty current duty count; busy high while in DEAD.
module hbridge_drive #(
  parameter int PWM_PERIOD       = 100,
  parameter int DUTY_MAX         = 100,
  parameter int RAMP_STEP_CYCLES = 1000,
  parameter int DEAD_CYCLES      = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in1,
  input  logic       in2,
  output logic       out_a,
  output logic       out_b,
  output logic [2:0] state,
  output logic [7:0] duty,
  output logic       busy
);

  localparam int RW = $clog2(RAMP_STEP_CYCLES + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);

  localparam logic [7:0]    PCNT_LAST = 8'(PWM_PERIOD - 1);
  localparam logic [7:0]    DUTY_TOP  = 8'(DUTY_MAX);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_STEP_CYCLES - 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);
  localparam logic [DW-1:0] DEAD_LAST = DW'(1);

  localparam logic [1:0] CMD_STOP  = 2'b00;
  localparam logic [1:0] CMD_REV   = 2'b01;
  localparam logic [1:0] CMD_FWD   = 2'b10;
  localparam logic [1:0] CMD_BRAKE = 2'b11;

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_FWD   = 3'd1,
    ST_REV   = 3'd2,
    ST_DEAD  = 3'd3,
    ST_BRAKE = 3'd4
  } state_t;

  function automatic state_t cmd_state(input logic [1:0] c);
    case (c)
      CMD_FWD:  return ST_FWD;
      CMD_REV:  return ST_REV;
      CMD_STOP: return ST_STOP;
      default:  return ST_BRAKE;
    endcase
  endfunction

  logic          r_in1_s1, r_in1_s2, r_in2_s1, r_in2_s2;
  logic [7:0]    r_pcnt;
  logic [7:0]    r_duty;
  logic [RW-1:0] r_rtmr;
  logic [DW-1:0] r_dtmr;
  logic          r_out_a, r_out_b;
  state_t        r_state;

  logic [1:0]    w_cmd;
  logic          w_run_same;

  assign w_cmd      = {r_in1_s2, r_in2_s2};
  // Command agrees with the direction already being driven: keep ramping.
  assign w_run_same = ((r_state == ST_FWD) && (w_cmd == CMD_FWD)) ||
                      ((r_state == ST_REV) && (w_cmd == CMD_REV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in1_s1 <= 1'b0;
      r_in1_s2 <= 1'b0;
      r_in2_s1 <= 1'b0;
      r_in2_s2 <= 1'b0;
      r_pcnt   <= '0;
      r_duty   <= '0;
      r_rtmr   <= '0;
      r_dtmr   <= '0;
      r_out_a  <= 1'b0;
      r_out_b  <= 1'b0;
      r_state  <= ST_STOP;
    end else begin
      r_in1_s1 <= in1;
      r_in1_s2 <= r_in1_s1;
      r_in2_s1 <= in2;
      r_in2_s2 <= r_in2_s1;

      // PWM counter free-runs regardless of state so the carrier phase never jumps.
      r_pcnt <= (r_pcnt == PCNT_LAST) ? 8'd0 : r_pcnt + 8'd1;

      // Legs follow the state one edge later; only BRAKE drives both high.
      r_out_a <= ((r_state == ST_FWD) && (r_pcnt < r_duty)) || (r_state == ST_BRAKE);
      r_out_b <= ((r_state == ST_REV) && (r_pcnt < r_duty)) || (r_state == ST_BRAKE);

      // Duty and ramp timer sit at zero everywhere except while ramping in FWD/REV,
      // so every entry into a run state starts from duty 0.
      r_duty <= '0;
      r_rtmr <= '0;

      case (r_state)
        ST_STOP: begin
          if (w_cmd != CMD_STOP) r_state <= cmd_state(w_cmd);
        end
        ST_FWD, ST_REV: begin
          if (w_run_same) begin
            if (r_rtmr == RAMP_LAST) begin
              r_duty <= (r_duty == DUTY_TOP) ? r_duty : r_duty + 8'd1;
            end else begin
              r_rtmr <= r_rtmr + 1'b1;
              r_duty <= r_duty;
            end
          end else if ((w_cmd == CMD_STOP) || (w_cmd == CMD_BRAKE)) begin
            r_state <= cmd_state(w_cmd);
          end else begin
            r_state <= ST_DEAD;
            r_dtmr  <= DEAD_LOAD;
          end
        end
        ST_BRAKE: begin
          if (w_cmd == CMD_STOP) begin
            r_state <= ST_STOP;
          end else if (w_cmd != CMD_BRAKE) begin
            r_state <= ST_DEAD;
            r_dtmr  <= DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          // BRAKE is always safe, so it cuts the dead time short; anything else waits it out.
          if (w_cmd == CMD_BRAKE) begin
            r_state <= ST_BRAKE;
          end else if (r_dtmr == DEAD_LAST) begin
            r_state <= cmd_state(w_cmd);
          end else begin
            r_dtmr <= r_dtmr - 1'b1;
          end
        end
        default: r_state <= ST_STOP;
      endcase
    end
  end

  assign out_a = r_out_a;
  assign out_b = r_out_b;
  assign state = r_state;
  assign duty  = r_duty;
  assign busy  = (r_state == ST_DEAD);

endmodule

// File: tb/tb_hbridge_drive.sv
// tb_hbridge_drive: directed scenarios plus randomized command sequences for hbridge_drive,
//   checked every cycle against a timestamp-based behavioural model.
// Latency/backpressure: not applicable (testbench).
module tb_hbridge_drive;
  localparam int P  = 10;
  localparam int DM = 10;
  localparam int RS = 2;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in1 = 1'b0;
  logic       in2 = 1'b0;
  logic       out_a, out_b, busy;
  logic [2:0] state;
  logic [7:0] duty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hbridge_drive #(
    .PWM_PERIOD(P), .DUTY_MAX(DM), .RAMP_STEP_CYCLES(RS), .DEAD_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2),
    .out_a(out_a), .out_b(out_b), .state(state), .duty(duty), .busy(busy)
  );

  // Behavioural model: modes 0 STOP,1 FWD,2 REV,3 DEAD,4 BRAKE.
  // Duty is derived from time spent in the run state, dead time from an exit timestamp.
  int         m_state = 0;
  int         m_duty = 0;
  int         m_pcnt = 0;
  logic       m_a = 1'b0;
  logic       m_b = 1'b0;
  logic [1:0] h1 = 2'b00;
  logic [1:0] h2 = 2'b00;
  logic [1:0] m_cmd;
  int         cyc = 0;
  int         run_start = 0;
  int         dead_until = 0;
  int         tgt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_duty = 0; m_pcnt = 0; m_a = 1'b0; m_b = 1'b0;
      h1 = 2'b00; h2 = 2'b00; cyc = 0; run_start = 0; dead_until = 0;
    end else begin
      m_a = ((m_state == 1) && (m_pcnt < m_duty)) || (m_state == 4);
      m_b = ((m_state == 2) && (m_pcnt < m_duty)) || (m_state == 4);
      m_cmd = h2;
      h2 = h1;
      h1 = {in1, in2};
      m_pcnt = (m_pcnt + 1) % P;
      cyc = cyc + 1;
      case (m_cmd)
        2'b10:   tgt = 1;
        2'b01:   tgt = 2;
        2'b00:   tgt = 0;
        default: tgt = 4;
      endcase
      case (m_state)
        0: if (tgt != 0) begin m_state = tgt; run_start = cyc; end
        1, 2: begin
          if (tgt == m_state) begin
          end else if (tgt == 0 || tgt == 4) begin
            m_state = tgt;
          end else begin
            m_state = 3; dead_until = cyc + DC;
          end
        end
        4: begin
          if (tgt == 0) m_state = 0;
          else if (tgt != 4) begin m_state = 3; dead_until = cyc + DC; end
        end
        default: begin
          if (tgt == 4) m_state = 4;
          else if (cyc == dead_until) begin m_state = tgt; run_start = cyc; end
        end
      endcase
      if (m_state == 1 || m_state == 2) begin
        m_duty = (cyc - run_start) / RS;
        if (m_duty > DM) m_duty = DM;
      end else begin
        m_duty = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (state !== 3'(m_state) || duty !== 8'(m_duty) || out_a !== m_a ||
        out_b !== m_b || busy !== (m_state == 3)) begin
      errors++;
      $display("FAIL model_compare t=%0t got state=%0d duty=%0d a=%b b=%b busy=%b, want state=%0d duty=%0d a=%b b=%b busy=%b",
               $time, state, duty, out_a, out_b, busy, m_state, m_duty, m_a, m_b, (m_state == 3));
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for busy, then returns how many cycles it stayed high.
  task automatic dead_len(output int n);
    int w;
    w = 0;
    n = 0;
    while (!busy && w < 40) begin @(negedge clk); w++; end
    while (busy && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic wait_busy(input string name);
    int w;
    w = 0;
    while (!busy && w < 40) begin @(negedge clk); w++; end
    chk(name, 32'(busy), 32'd1);
  endtask

  int n, hi_a, hi_b, r, hold;

  initial begin
    #1 rst_n = 1'b0;
    cyc_n(3);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_duty", 32'(duty), 32'd0);
    chk("reset_legs", {30'd0, out_a, out_b}, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc_n(2);

    // Forward from STOP: state on 3rd edge, ramp then constant-high leg.
    in1 = 1'b1; in2 = 1'b0;
    edges(2);
    chk("fwd_not_yet", 32'(state), 32'd0);
    edges(1);
    chk("fwd_3rd_edge", 32'(state), 32'd1);
    chk("fwd_entry_duty", 32'(duty), 32'd0);
    edges(2);
    chk("fwd_first_step", 32'(duty), 32'd1);
    cyc_n(22);
    chk("fwd_saturated", 32'(duty), 32'd10);
    hi_a = 0; hi_b = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      hi_a += int'(out_a);
      hi_b += int'(out_b);
    end
    chk("fwd_full_high", 32'(hi_a), 32'd10);
    chk("fwd_out_b_low", 32'(hi_b), 32'd0);

    // Reversal: dead time then REV ramp from 0.
    in1 = 1'b0; in2 = 1'b1;
    dead_len(n);
    chk("rev_dead_len", 32'(n), 32'd4);
    chk("rev_after_dead", 32'(state), 32'd2);
    chk("rev_duty_restart", 32'(duty), 32'd0);
    cyc_n(6);
    chk("rev_ramp", 32'(duty), 32'd3);

    // REV -> STOP directly, then BRAKE from STOP with output latency.
    in1 = 1'b0; in2 = 1'b0;
    cyc_n(4);
    chk("rev_to_stop", 32'(state), 32'd0);
    @(negedge clk);
    in1 = 1'b1; in2 = 1'b1;
    edges(3);
    chk("brake_state", 32'(state), 32'd4);
    chk("brake_legs_lag", {30'd0, out_a, out_b}, 32'd0);
    edges(1);
    chk("brake_legs", {30'd0, out_a, out_b}, 32'd3);
    @(negedge clk);
    in1 = 1'b1; in2 = 1'b0;
    dead_len(n);
    chk("brake_to_fwd_dead", 32'(n), 32'd4);
    chk("brake_to_fwd_state", 32'(state), 32'd1);
    chk("brake_to_fwd_duty", 32'(duty), 32'd0);

    // Glitch REV->FWD inside DEAD: full dead time, then FWD.
    cyc_n(22);
    in1 = 1'b0; in2 = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        if (n == 2) begin in1 = 1'b1; in2 = 1'b0; end
      end
    end
    chk("glitch_dead_len", 32'(n), 32'd4);
    chk("glitch_back_fwd", 32'(state), 32'd1);

    // BRAKE during DEAD cuts the dead time short.
    in1 = 1'b0; in2 = 1'b1;
    wait_busy("brake_in_dead_wait");
    in1 = 1'b1; in2 = 1'b1;
    edges(3);
    chk("brake_in_dead", 32'(state), 32'd4);

    // FWD to duty 5, then STOP with no DEAD, then REV directly.
    @(negedge clk);
    in1 = 1'b1; in2 = 1'b0;
    dead_len(n);
    cyc_n(10);
    chk("fwd_duty5", 32'(duty), 32'd5);
    in1 = 1'b0; in2 = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); n += int'(busy); end
    chk("stop_no_dead", 32'(n), 32'd0);
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_leg", 32'(out_a), 32'd0);
    in1 = 1'b0; in2 = 1'b1;
    edges(3);
    chk("stop_to_rev", 32'(state), 32'd2);

    // Reset asserted mid-FWD drops legs immediately.
    @(negedge clk);
    in1 = 1'b1; in2 = 1'b0;
    cyc_n(30);
    chk("pre_reset_leg", 32'(out_a), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_legs", {30'd0, out_a, out_b}, 32'd0);
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_duty", 32'(duty), 32'd0);
    cyc_n(3);
    chk("reset_hold", {29'd0, out_a, out_b, busy}, 32'd0);
    rst_n = 1'b1;

    // Randomized command sequences with occasional short glitches and resets.
    for (int s = 0; s < 300; s++) begin
      r = int'($urandom_range(0, 3));
      in1 = r[1];
      in2 = r[0];
      if ($urandom_range(0, 5) == 0) hold = int'($urandom_range(1, 3));
      else hold = int'($urandom_range(4, 40));
      if ($urandom_range(0, 60) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      cyc_n(hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
